rename_map_ckpt: RTL and testbench
==================================

// Module: rename_map_ckpt
// PURPOSE
//  Parametrised register-rename stage: RAT lookup, bitmap free list, ready table, retirement map (RRAT).
//  Renames one instruction per cycle under a valid/ready handshake and frees the old mapping at retire.
//  Restores the committed map in one cycle on flush. Sits between decode and dispatch/ROB.
// PARAMETERS
//  NUM_ARCH_REGS  32  architectural registers; index 0 is hardwired zero
//  NUM_PHYS_REGS  64  physical registers; must be > NUM_ARCH_REGS
//  ARCH_W  $clog2(NUM_ARCH_REGS)  arch index width (derived)
//  PHYS_W  $clog2(NUM_PHYS_REGS)  phys tag width (derived)
// PORTS
//  clk                 in   1       clock, all state updates on posedge
//  reset               in   1       synchronous, active-high
//  rename_valid        in   1       decode presents an instruction
//  rename_ready        out  1       free reg available and no flush this cycle
//  rd, rs1, rs2        in   ARCH_W  architectural dest/sources
//  rd_write            in   1       instruction writes rd (stores/branches = 0)
//  phys_rd             out  PHYS_W  allocated dest tag (0 if no allocation)
//  old_phys_rd         out  PHYS_W  previous mapping of rd (0 if no allocation), goes to ROB
//  phys_rs1, phys_rs2  out  PHYS_W  current source mappings
//  rs1_ready, rs2_ready out 1       source value already produced
//  complete_valid      in   1       execution writeback
//  complete_phys_reg   in   PHYS_W  tag written back
//  retire_valid        in   1       ROB commits head instruction
//  retire_arch_rd      in   ARCH_W  committed arch dest
//  retire_phys_rd      in   PHYS_W  committed new tag
//  retire_old_phys_rd  in   PHYS_W  tag to free
//  flush               in   1       squash all in-flight, restore RRAT
//  free_count          out  PHYS_W+1 number of free phys regs (registered state)
// BEHAVIOUR
//  Reset: RAT[i]=RRAT[i]=i; free[p]=1 for p>=NUM_ARCH_REGS else 0; ready all 1; free_count=NUM_PHYS-NUM_ARCH.
//  Fire = rename_valid & rename_ready. Lookup outputs are combinational and driven every cycle.
//  alloc = rd_write & (rd!=0). phys_rd = lowest-index free tag when alloc, else 0.
//  rename_ready = !flush & (!alloc | free_count!=0). When no tag is free and alloc=1: ready=0, stall, no state change.
//  On fire & alloc (posedge): RAT[rd]<=phys_rd, free[phys_rd]<=0, ready[phys_rd]<=0.
//  On fire & !alloc: no state change (x0 writes are never renamed; phys 0 is never freed or allocated).
//  Sources read the RAT before this cycle's update; rs==rd in the same instruction gives the OLD tag.
//  Ready bypass: rsN_ready = ready[phys_rsN] | (complete_valid & complete_phys_reg==phys_rsN).
//  complete_valid: ready[complete_phys_reg]<=1.
//  retire_valid: RRAT[retire_arch_rd]<=retire_phys_rd; free[retire_old_phys_rd]<=1 unless tag 0.
//    A freed tag is allocatable from the next cycle only; no same-cycle forwarding into the free list.
//  Simultaneous alloc and retire in one cycle: both apply; tags are distinct by construction.
//    free_count changes by +1-1 = 0.
//  flush (priority over rename; rename_ready=0 that cycle):
//    Same-cycle retire is older and is applied first: RRAT_next = RRAT with retire merged.
//    RAT <= RRAT_next.
//    free[p] <= 1 iff p not referenced by any RRAT_next entry and p!=0.
//    ready <= all 1.
//    free_count <= popcount of the new free vector.
//    Same-cycle complete is ignored by the flush result.
//  free_count is updated each cycle as +retire_free - alloc_fire, or recomputed on flush.
//    Never exceeds NUM_PHYS-NUM_ARCH; never underflows.
//  Reset asserted mid-stream overrides everything and restores reset state in one cycle.
// TESTING
//  Reset, then rename rd=5 rs1=5 rs2=0 -> phys_rd=32, old_phys_rd=5, phys_rs1=5, rs1_ready=1; next cycle RAT[5]=32.
//  Back-to-back rd=5 twice -> second gives old_phys_rd=32, phys_rd=33; rs1=5 reads 32, ready=0 until complete 32.
//  Rename rs1 whose tag is completing that cycle -> rs1_ready=1 via bypass.
//  Exhaust: 32 allocations -> free_count=0, rename_ready=0 for rd_write=1.
//    Still 1 for rd=0 or rd_write=0.
//    Retire freeing tag 40 -> ready next cycle, phys_rd=40.
//  Rename rd=0 rd_write=1 -> phys_rd=0, no free_count change.
//  Rename 3 dests (32,33,34); retire first (arch 1, new 32, old 1) together with flush.
//    Next cycle: RAT[1]=32, RAT[2]=2, RAT[3]=3.
//    Free: tag 1 free, 33 and 34 free, 32 not free; free_count=32; all ready.

Source files
------------

// File: rtl/rename_map_ckpt.sv
// rtl/rename_map_ckpt.sv - register rename stage with RAT, bitmap free list, ready table and RRAT
// Renames one instruction per cycle; flush restores the committed map in a single cycle.
module rename_map_ckpt #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_PHYS_REGS = 64,
  localparam int ARCH_W = $clog2(NUM_ARCH_REGS),
  localparam int PHYS_W = $clog2(NUM_PHYS_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rename_valid,
  output logic              rename_ready,
  input  logic [ARCH_W-1:0] rd,
  input  logic [ARCH_W-1:0] rs1,
  input  logic [ARCH_W-1:0] rs2,
  input  logic              rd_write,
  output logic [PHYS_W-1:0] phys_rd,
  output logic [PHYS_W-1:0] old_phys_rd,
  output logic [PHYS_W-1:0] phys_rs1,
  output logic [PHYS_W-1:0] phys_rs2,
  output logic              rs1_ready,
  output logic              rs2_ready,
  input  logic              complete_valid,
  input  logic [PHYS_W-1:0] complete_phys_reg,
  input  logic              retire_valid,
  input  logic [ARCH_W-1:0] retire_arch_rd,
  input  logic [PHYS_W-1:0] retire_phys_rd,
  input  logic [PHYS_W-1:0] retire_old_phys_rd,
  input  logic              flush,
  output logic [PHYS_W:0]   free_count
);

  logic [PHYS_W-1:0]        rat_q  [NUM_ARCH_REGS];
  logic [PHYS_W-1:0]        rrat_q [NUM_ARCH_REGS];
  logic [NUM_PHYS_REGS-1:0] free_q;
  logic [NUM_PHYS_REGS-1:0] ready_q;
  logic [PHYS_W:0]          free_count_q;

  logic                     alloc;
  logic                     fire_alloc;
  logic                     retire_free;
  logic [PHYS_W-1:0]        free_tag;

  logic [PHYS_W-1:0]        rrat_next [NUM_ARCH_REGS];
  logic [NUM_PHYS_REGS-1:0] referenced;
  logic [NUM_PHYS_REGS-1:0] flush_free;
  logic [PHYS_W:0]          flush_count;

  // Lowest-index free tag; tag 0 is never marked free so 0 means "none".
  always_comb begin
    free_tag = '0;
    for (int p = NUM_PHYS_REGS - 1; p >= 1; p--) begin
      if (free_q[p]) free_tag = PHYS_W'(p);
    end
  end

  assign alloc        = rd_write && (rd != '0);
  assign rename_ready = !flush && (!alloc || (free_count_q != '0));
  assign fire_alloc   = rename_valid && rename_ready && alloc;
  assign retire_free  = retire_valid && (retire_old_phys_rd != '0);

  assign phys_rd     = alloc ? free_tag : '0;
  assign old_phys_rd = alloc ? rat_q[rd] : '0;
  assign phys_rs1    = rat_q[rs1];
  assign phys_rs2    = rat_q[rs2];
  assign rs1_ready   = ready_q[phys_rs1] || (complete_valid && (complete_phys_reg == phys_rs1));
  assign rs2_ready   = ready_q[phys_rs2] || (complete_valid && (complete_phys_reg == phys_rs2));
  assign free_count  = free_count_q;

  // Flush image: committed map with this cycle's (older) retire merged in,
  // and every tag it does not reference becomes free.
  always_comb begin
    for (int i = 0; i < NUM_ARCH_REGS; i++) rrat_next[i] = rrat_q[i];
    if (retire_valid && (retire_arch_rd != '0)) rrat_next[retire_arch_rd] = retire_phys_rd;
    referenced = '0;
    for (int i = 0; i < NUM_ARCH_REGS; i++) referenced[rrat_next[i]] = 1'b1;
    flush_free    = ~referenced;
    flush_free[0] = 1'b0;
    flush_count   = '0;
    for (int p = 0; p < NUM_PHYS_REGS; p++) begin
      flush_count = flush_count + {{PHYS_W{1'b0}}, flush_free[p]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        rat_q[i]  <= PHYS_W'(i);
        rrat_q[i] <= PHYS_W'(i);
      end
      for (int p = 0; p < NUM_PHYS_REGS; p++) free_q[p] <= (p >= NUM_ARCH_REGS);
      ready_q      <= '1;
      free_count_q <= (PHYS_W+1)'(NUM_PHYS_REGS - NUM_ARCH_REGS);
    end else if (flush) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        rat_q[i]  <= rrat_next[i];
        rrat_q[i] <= rrat_next[i];
      end
      free_q       <= flush_free;
      ready_q      <= '1;
      free_count_q <= flush_count;
    end else begin
      if (complete_valid) ready_q[complete_phys_reg] <= 1'b1;
      if (fire_alloc) begin
        rat_q[rd]         <= free_tag;
        free_q[free_tag]  <= 1'b0;
        ready_q[free_tag] <= 1'b0;
      end
      if (retire_valid && (retire_arch_rd != '0)) rrat_q[retire_arch_rd] <= retire_phys_rd;
      if (retire_free) free_q[retire_old_phys_rd] <= 1'b1;
      free_count_q <= free_count_q + {{PHYS_W{1'b0}}, retire_free}
                                   - {{PHYS_W{1'b0}}, fire_alloc};
    end
  end

endmodule

// File: tb/tb_rename_map_ckpt.sv
// tb/tb_rename_map_ckpt.sv - self-checking bench for rename_map_ckpt
// Directed scenarios plus randomized traffic against an array-based reference model.
module tb_rename_map_ckpt;
  localparam int NA = 32;
  localparam int NP = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, rename_valid, rd_write, complete_valid, retire_valid, flush;
  logic [4:0] rd, rs1, rs2, retire_arch_rd;
  logic [5:0] complete_phys_reg, retire_phys_rd, retire_old_phys_rd;
  logic       rename_ready, rs1_ready, rs2_ready;
  logic [5:0] phys_rd, old_phys_rd, phys_rs1, phys_rs2;
  logic [6:0] free_count;

  rename_map_ckpt #(.NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP)) dut (
    .clk(clk), .reset(reset),
    .rename_valid(rename_valid), .rename_ready(rename_ready),
    .rd(rd), .rs1(rs1), .rs2(rs2), .rd_write(rd_write),
    .phys_rd(phys_rd), .old_phys_rd(old_phys_rd),
    .phys_rs1(phys_rs1), .phys_rs2(phys_rs2),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .complete_valid(complete_valid), .complete_phys_reg(complete_phys_reg),
    .retire_valid(retire_valid), .retire_arch_rd(retire_arch_rd),
    .retire_phys_rd(retire_phys_rd), .retire_old_phys_rd(retire_old_phys_rd),
    .flush(flush), .free_count(free_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain arrays of the architectural state.
  int m_rat  [NA];
  int m_rrat [NA];
  bit m_free [NP];
  bit m_rdy  [NP];

  typedef struct { int arch; int newp; int oldp; } rob_t;
  rob_t rob[$];
  bit   rob_pop;

  function automatic int m_free_count();
    int n = 0;
    for (int p = 0; p < NP; p++) n += int'(m_free[p]);
    return n;
  endfunction

  function automatic int m_lowest();
    for (int p = 1; p < NP; p++) if (m_free[p]) return p;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin m_rat[i] = i; m_rrat[i] = i; end
    for (int p = 0; p < NP; p++) begin m_free[p] = (p >= NA); m_rdy[p] = 1'b1; end
    rob.delete();
  endtask

  task automatic set_idle();
    rename_valid = 0; rd_write = 0; rd = 0; rs1 = 0; rs2 = 0;
    complete_valid = 0; complete_phys_reg = 0;
    retire_valid = 0; retire_arch_rd = 0; retire_phys_rd = 0; retire_old_phys_rd = 0;
    flush = 0; rob_pop = 0;
  endtask

  // One clock: compare every output against the model mid-cycle, then advance both.
  task automatic cycle();
    bit alloc, e_ready;
    int e_rs1, e_rs2, tag;
    @(negedge clk);
    alloc   = rd_write && (rd != 0);
    e_ready = !flush && (!alloc || m_free_count() > 0);
    e_rs1   = m_rat[rs1];
    e_rs2   = m_rat[rs2];
    check("rename_ready", int'(rename_ready), int'(e_ready));
    check("phys_rd", int'(phys_rd), alloc ? m_lowest() : 0);
    check("old_phys_rd", int'(old_phys_rd), alloc ? m_rat[rd] : 0);
    check("phys_rs1", int'(phys_rs1), e_rs1);
    check("phys_rs2", int'(phys_rs2), e_rs2);
    check("rs1_ready", int'(rs1_ready), int'(m_rdy[e_rs1] || (complete_valid && complete_phys_reg == e_rs1)));
    check("rs2_ready", int'(rs2_ready), int'(m_rdy[e_rs2] || (complete_valid && complete_phys_reg == e_rs2)));
    check("free_count", int'(free_count), m_free_count());
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (flush) begin
      if (retire_valid && retire_arch_rd != 0) m_rrat[retire_arch_rd] = retire_phys_rd;
      for (int p = 0; p < NP; p++) begin m_free[p] = (p != 0); m_rdy[p] = 1'b1; end
      for (int i = 0; i < NA; i++) begin m_rat[i] = m_rrat[i]; m_free[m_rrat[i]] = 1'b0; end
      rob.delete();
    end else begin
      if (complete_valid) m_rdy[complete_phys_reg] = 1'b1;
      if (rename_valid && e_ready && alloc) begin
        tag = m_lowest();
        rob.push_back('{arch: int'(rd), newp: tag, oldp: m_rat[rd]});
        m_rat[rd] = tag; m_free[tag] = 1'b0; m_rdy[tag] = 1'b0;
      end
      if (retire_valid) begin
        if (retire_arch_rd != 0) m_rrat[retire_arch_rd] = retire_phys_rd;
        if (retire_old_phys_rd != 0) m_free[retire_old_phys_rd] = 1'b1;
        if (rob_pop) void'(rob.pop_front());
      end
    end
    #1;
  endtask

  task automatic do_reset();
    set_idle(); reset = 1; cycle(); cycle(); reset = 0;
  endtask

  task automatic rename_one(input int d, input int s1, input int s2);
    set_idle(); rename_valid = 1; rd_write = 1; rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
  endtask

  initial begin
    reset = 1; set_idle(); model_reset();
    #1;
    do_reset();
    check("reset_free_count", int'(free_count), 32);

    // First rename of x5, source x5 sees the old tag
    rename_one(5, 5, 0); #1;
    check("d1_phys_rd", int'(phys_rd), 32);
    check("d1_old", int'(old_phys_rd), 5);
    check("d1_rs1", int'(phys_rs1), 5);
    check("d1_rs1_ready", int'(rs1_ready), 1);
    cycle();
    rename_one(5, 5, 0); #1;
    check("d2_phys_rd", int'(phys_rd), 33);
    check("d2_old", int'(old_phys_rd), 32);
    check("d2_rs1", int'(phys_rs1), 32);
    check("d2_rs1_ready", int'(rs1_ready), 0);
    cycle();
    // Bypass from same-cycle completion, with an x0 write that must not allocate
    rename_one(0, 5, 0); complete_valid = 1; complete_phys_reg = 33; #1;
    check("byp_rs1_ready", int'(rs1_ready), 1);
    check("x0_phys_rd", int'(phys_rd), 0);
    cycle();
    check("x0_free_count", int'(free_count), 30);

    // Exhaust the free list
    do_reset();
    for (int i = 0; i < 32; i++) begin rename_one(1 + (i % 31), 0, 0); cycle(); end
    set_idle(); rd_write = 1; rd = 3; #1;
    check("ex_free_count", int'(free_count), 0);
    check("ex_ready_alloc", int'(rename_ready), 0);
    rd = 0; #1;
    check("ex_ready_x0", int'(rename_ready), 1);
    rd = 3; rd_write = 0; #1;
    check("ex_ready_nowrite", int'(rename_ready), 1);
    rename_valid = 1; rd_write = 1; cycle();
    set_idle(); retire_valid = 1; retire_arch_rd = 9; retire_phys_rd = 40; retire_old_phys_rd = 40; #1;
    check("ex_no_fwd", int'(rename_ready), 1);
    cycle();
    rename_one(3, 0, 0); #1;
    check("ex_ready_after", int'(rename_ready), 1);
    check("ex_phys_rd", int'(phys_rd), 40);
    cycle();

    // Flush with a same-cycle retire
    do_reset();
    for (int i = 1; i <= 3; i++) begin rename_one(i, 0, 0); cycle(); end
    set_idle(); retire_valid = 1; retire_arch_rd = 1; retire_phys_rd = 32; retire_old_phys_rd = 1; flush = 1;
    rd_write = 1; rd = 7; rename_valid = 1; #1;
    check("fl_ready", int'(rename_ready), 0);
    cycle();
    set_idle(); rs1 = 1; rs2 = 2; #1;
    check("fl_rat1", int'(phys_rs1), 32);
    check("fl_rat2", int'(phys_rs2), 2);
    check("fl_rdy1", int'(rs1_ready), 1);
    check("fl_free_count", int'(free_count), 32);
    rs1 = 3; #1;
    check("fl_rat3", int'(phys_rs1), 3);
    rename_one(4, 0, 0); #1;
    check("fl_alloc1", int'(phys_rd), 1);
    cycle();
    rename_one(4, 0, 0); #1;
    check("fl_alloc33", int'(phys_rd), 33);
    cycle();

    // Randomized traffic with a ROB-ordered retire stream
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      rename_valid = ($urandom_range(0, 9) < 6);
      rd_write     = ($urandom_range(0, 3) != 0);
      rd  = 5'($urandom_range(0, NA - 1));
      rs1 = 5'($urandom_range(0, NA - 1));
      rs2 = 5'($urandom_range(0, NA - 1));
      if (rob.size() > 0 && $urandom_range(0, 1) == 1) begin
        complete_valid = 1;
        complete_phys_reg = 6'(rob[$urandom_range(0, rob.size() - 1)].newp);
      end
      if (rob.size() > 0 && $urandom_range(0, 9) < 3) begin
        retire_valid = 1; rob_pop = 1;
        retire_arch_rd = 5'(rob[0].arch);
        retire_phys_rd = 6'(rob[0].newp);
        retire_old_phys_rd = 6'(rob[0].oldp);
      end
      flush = ($urandom_range(0, 99) < 2);
      reset = ($urandom_range(0, 999) < 3);
      cycle();
      reset = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
